// File: rtl/run_seq_pkg.sv
// Shared state encoding and default sizing for the run sequencer.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } run_state_e;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam logic [15:0] DEF_MAX_CYCLES = 16'd60000;

endpackage

// File: rtl/run_sequencer_cycle_counter.sv
// Saturating up-counter with synchronous clear and enable; clear has priority.
module cycle_counter #(
    parameter int unsigned  W   = 16,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: holds at MAX instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != MAX)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/run_sequencer.sv
// Launches NUM_PROGS programs on the core via start/halt and reports per-program cycle counts.
// Optional RUN_SEQ_PERF_EN adds a total_cycles accumulator output.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned      NUM_PROGS    = 3,
    parameter int unsigned      START_CYCLES = 2,
    parameter int unsigned      CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int unsigned      PSEL_W       = $clog2(NUM_PROGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              halt,
    output logic              start,
    output logic [PSEL_W-1:0] prog_sel,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  last_cycles,
    output logic              result_valid
`ifdef RUN_SEQ_PERF_EN
    ,
    output logic [CNT_W+PSEL_W-1:0] total_cycles
`endif
);

    localparam logic [PSEL_W-1:0] LAST_PROG  = PSEL_W'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0]  LAUNCH_END = CNT_W'(START_CYCLES - 1);

    run_state_e        state_r, state_s;
    logic              start_r, start_s;
    logic [PSEL_W-1:0] prog_sel_r, prog_sel_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              timeout_r, timeout_s;
    logic [CNT_W-1:0]  last_cycles_r, last_cycles_s;
    logic              result_valid_r, result_valid_s;
    logic              armed_r, armed_s;

    logic              launch_clr_s, launch_en_s;
    logic              cycle_clr_s, cycle_en_s;
    logic [CNT_W-1:0]  launch_cnt_s, cycle_cnt_s;

    cycle_counter #(
        .W   (CNT_W),
        .MAX (MAX_CYCLES)
    ) u_launch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (launch_clr_s),
        .en    (launch_en_s),
        .count (launch_cnt_s)
    );

    cycle_counter #(
        .W   (CNT_W),
        .MAX (MAX_CYCLES)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cycle_clr_s),
        .en    (cycle_en_s),
        .count (cycle_cnt_s)
    );

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_s        = state_r;
        prog_sel_s     = prog_sel_r;
        timeout_s      = timeout_r;
        last_cycles_s  = last_cycles_r;
        result_valid_s = 1'b0;
        armed_s        = armed_r;
        launch_clr_s   = 1'b0;
        launch_en_s    = 1'b0;
        cycle_clr_s    = 1'b0;
        cycle_en_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (go) begin
                    state_s      = LAUNCH;
                    prog_sel_s   = {PSEL_W{1'b0}};
                    timeout_s    = 1'b0;
                    armed_s      = 1'b0;
                    launch_clr_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: begin
                launch_en_s = 1'b1;
                // A high halt here is the core still held in reset; only a low sample arms.
                if (!halt) begin
                    armed_s = 1'b1;
                end else begin
                    armed_s = armed_r;
                end
                if (launch_cnt_s == LAUNCH_END) begin
                    state_s     = RUN;
                    cycle_clr_s = 1'b1;
                end else begin
                    state_s = LAUNCH;
                end
            end
            RUN: begin
                if (halt && armed_r) begin
                    state_s        = NEXT;
                    last_cycles_s  = cycle_cnt_s;
                    result_valid_s = 1'b1;
                end else if (cycle_cnt_s == MAX_CYCLES) begin
                    state_s        = DONE;
                    timeout_s      = 1'b1;
                    last_cycles_s  = MAX_CYCLES;
                    result_valid_s = 1'b1;
                end else begin
                    state_s    = RUN;
                    cycle_en_s = 1'b1;
                    if (!halt) begin
                        armed_s = 1'b1;
                    end else begin
                        armed_s = armed_r;
                    end
                end
            end
            NEXT: begin
                armed_s = 1'b0;
                if (prog_sel_r == LAST_PROG) begin
                    state_s = DONE;
                end else begin
                    state_s      = LAUNCH;
                    prog_sel_s   = prog_sel_r + PSEL_W'(1);
                    launch_clr_s = 1'b1;
                end
            end
            DONE: begin
                if (!go) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        start_s = (state_s != RUN);
        busy_s  = (state_s == LAUNCH) || (state_s == RUN) || (state_s == NEXT);
        done_s  = (state_s == DONE);
    end

    // State and registered output bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            start_r        <= 1'b1;
            prog_sel_r     <= {PSEL_W{1'b0}};
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            timeout_r      <= 1'b0;
            last_cycles_r  <= {CNT_W{1'b0}};
            result_valid_r <= 1'b0;
            armed_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            start_r        <= start_s;
            prog_sel_r     <= prog_sel_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            timeout_r      <= timeout_s;
            last_cycles_r  <= last_cycles_s;
            result_valid_r <= result_valid_s;
            armed_r        <= armed_s;
        end
    end

    assign start        = start_r;
    assign prog_sel     = prog_sel_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign timeout      = timeout_r;
    assign last_cycles  = last_cycles_r;
    assign result_valid = result_valid_r;

`ifdef RUN_SEQ_PERF_EN
    localparam int unsigned TOT_W = CNT_W + PSEL_W;

    logic [TOT_W-1:0] total_r;

    // Per-request sum of reported counts, cleared when a new request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_r <= {TOT_W{1'b0}};
        end else if ((state_r == IDLE) && (state_s == LAUNCH)) begin
            total_r <= {TOT_W{1'b0}};
        end else if (result_valid_s) begin
            total_r <= total_r + TOT_W'(last_cycles_s);
        end else begin
            total_r <= total_r;
        end
    end

    assign total_cycles = total_r;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: drives a core model on halt and scoreboards reported cycle counts.
`timescale 1ns/1ps
module tb_run_sequencer;

    localparam int unsigned MAXC = 50;

    logic        clk;
    logic        reset;
    logic        go;
    logic        halt;
    logic        start;
    logic [1:0]  prog_sel;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] last_cycles;
    logic        result_valid;
`ifdef RUN_SEQ_PERF_EN
    logic [17:0] total_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] cycles;
        logic [1:0]  psel;
        logic        to;
    } exp_t;

    exp_t exp_q[$];

    run_sequencer #(
        .NUM_PROGS    (3),
        .START_CYCLES (2),
        .CNT_W        (16),
        .MAX_CYCLES   (16'd50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .halt         (halt),
        .start        (start),
        .prog_sel     (prog_sel),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .last_cycles  (last_cycles),
        .result_valid (result_valid)
`ifdef RUN_SEQ_PERF_EN
        ,
        .total_cycles (total_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every result_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rv", 32'(result_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_last_cycles", 32'(last_cycles), 32'(e.cycles));
                chk("sb_prog_sel", 32'(prog_sel), 32'(e.psel));
                chk("sb_timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    // Core model for one program: halt high for `stale` RUN cycles, low for `low`, then high.
    task automatic run_prog(input int stale, input int low, input logic [1:0] psel, input logic to);
        int   n;
        int   r;
        int   launch_len;
        bit   seen;
        exp_t e;
        e.cycles = to ? 16'(MAXC) : 16'(stale + low);
        e.psel   = psel;
        e.to     = to;
        exp_q.push_back(e);
        halt       = (stale > 0) ? 1'b1 : 1'b0;
        n          = 0;
        launch_len = 0;
        do begin
            @(negedge clk);
            n++;
            if (start === 1'b1 && busy === 1'b1) launch_len++;
        end while (start !== 1'b0 && n < 20);
        chk("launch_len", 32'(launch_len), 32'd2);
        chk("run_prog_sel", 32'(prog_sel), 32'(psel));
        chk("run_busy", 32'(busy), 32'd1);
        r    = 0;
        seen = 1'b0;
        while (!seen && r < 60) begin
            halt = (r < stale || r >= stale + low) ? 1'b1 : 1'b0;
            @(negedge clk);
            seen = (result_valid === 1'b1);
            r++;
        end
        chk("result_seen", 32'(seen), 32'd1);
    endtask

    task automatic finish_run(input logic exp_to, input logic [1:0] exp_psel, input int exp_total);
        @(negedge clk);
        chk("done_set", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_start", 32'(start), 32'd1);
        chk("done_rv", 32'(result_valid), 32'd0);
        chk("done_timeout", 32'(timeout), 32'(exp_to));
        chk("done_prog_sel", 32'(prog_sel), 32'(exp_psel));
`ifdef RUN_SEQ_PERF_EN
        chk("total_cycles", 32'(total_cycles), 32'(exp_total));
`endif
        repeat (2) begin
            @(negedge clk);
            chk("done_hold", 32'(done), 32'd1);
            chk("done_hold_start", 32'(start), 32'd1);
        end
        go = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_timeout", 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        go    = 1'b0;
        halt  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_prog_sel", 32'(prog_sel), 32'd0);
        chk("rst_last", 32'(last_cycles), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_parked", 32'(start), 32'd1);

        // Three programs, each halting 10 cycles after start falls.
        go = 1'b1;
        run_prog(0, 10, 2'd0, 1'b0);
        run_prog(0, 10, 2'd1, 1'b0);
        run_prog(0, 10, 2'd2, 1'b0);
        finish_run(1'b0, 2'd2, 30);

        // Stale halt, first-cycle halt, then a longer run.
        go = 1'b1;
        run_prog(3, 4, 2'd0, 1'b0);
        run_prog(0, 0, 2'd1, 1'b0);
        run_prog(0, 30, 2'd2, 1'b0);
        finish_run(1'b0, 2'd2, 37);

        // Varied lengths for the accumulator.
        go = 1'b1;
        run_prog(0, 10, 2'd0, 1'b0);
        run_prog(0, 20, 2'd1, 1'b0);
        run_prog(0, 30, 2'd2, 1'b0);
        finish_run(1'b0, 2'd2, 60);

        // Program 1 never halts: watchdog aborts, program 2 never launches.
        go = 1'b1;
        run_prog(0, 5, 2'd0, 1'b0);
        run_prog(0, 1000, 2'd1, 1'b1);
        chk("to_done_now", 32'(done), 32'd1);
        finish_run(1'b1, 2'd1, 55);

        // New request clears timeout; reset mid-RUN of program 1 then restart.
        go = 1'b1;
        run_prog(0, 5, 2'd0, 1'b0);
        halt = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start !== 1'b0 && n < 20);
        chk("mid_run_reached", 32'(start), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_start", 32'(start), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_prog_sel", 32'(prog_sel), 32'd0);
        chk("mrst_timeout", 32'(timeout), 32'd0);
        chk("mrst_rv", 32'(result_valid), 32'd0);
        chk("mrst_last", 32'(last_cycles), 32'd0);
        reset = 1'b0;
        run_prog(0, 10, 2'd0, 1'b0);
        run_prog(0, 3, 2'd1, 1'b0);
        run_prog(0, 4, 2'd2, 1'b0);
        finish_run(1'b0, 2'd2, 17);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
